uart_rx_framed: RTL and testbench
=================================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 65_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9_600, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; legal values are even and at least 8.
REQ-004 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range is 5..9.
REQ-005 The block SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-007 clk  in  1  the single system clock; all state SHALL be clocked on its rising edge.
REQ-008 rst  in  1  one clock; reset is asynchronous and active-low.
REQ-009 rxd  in  1  asynchronous serial line; idles high.
REQ-010 rx_data  out  DATA_BITS  received payload, LSB first on the line.
REQ-011 rx_valid  out  1  rx_data and the error flags are valid.
REQ-012 rx_ready  in  1  the consumer accepts the word when rx_valid and rx_ready are both 1 in the same cycle.
REQ-013 parity_err  out  1  parity mismatch on the held word.
REQ-014 frame_err  out  1  a stop bit was sampled low on the held word.
REQ-015 overrun  out  1  one or more frames were dropped while rx_valid was high.
REQ-016 busy  out  1  the FSM is not in IDLE.

Function
REQ-017 rxd SHALL pass through a 2-FF synchroniser before use; only the synchronised value is used downstream.
REQ-018 The tick divider SHALL be DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), with a minimum of 1; it SHALL emit a 1-cycle tick every DIV clocks.
REQ-019 The tick divider SHALL restart from 0 in the cycle a falling edge is detected in IDLE, so that the bit phase aligns to the start edge.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; a sample counter 0..OVERSAMPLE-1 SHALL advance on each tick and wrap to 0 at each bit boundary.
REQ-021 Each bit value SHALL be the 2-of-3 majority of the samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-022 In IDLE, a synchronised rxd of 0 SHALL move the FSM to START.
REQ-023 In START, if the start-bit majority is 1, the FSM SHALL treat it as a false start and return to IDLE with no output and no flag change.
REQ-024 In START, if the start-bit majority is 0, the FSM SHALL move to DATA at the end of the bit.
REQ-025 DATA SHALL shift DATA_BITS bits LSB first; after the last bit the FSM SHALL go to PARITY when PARITY != 0, otherwise to STOP.
REQ-026 In PARITY, the error SHALL be computed as: odd mode, error when XOR(data, p) = 0; even mode, error when XOR(data, p) = 1.
REQ-027 In STOP, each stop bit sampled low SHALL set the frame error for the frame.
REQ-028 The frame SHALL commit at the majority sample of the final stop bit, with no wait for the bit end; the FSM SHALL return to IDLE in the same cycle so a back-to-back start edge is caught.
REQ-029 On commit with rx_valid = 0, the block SHALL load rx_data, parity_err and frame_err and set rx_valid = 1 in the next cycle.
REQ-030 rx_valid, rx_data, parity_err and frame_err SHALL stay stable until a handshake occurs; the handshake SHALL clear rx_valid next cycle.
REQ-031 On commit with rx_valid = 1 and no handshake in that cycle, the new frame SHALL be discarded, the held word kept and overrun set.
REQ-032 A commit in the same cycle as a handshake SHALL load the new word, keep rx_valid = 1 and not set overrun.
REQ-033 overrun SHALL be sticky and SHALL clear on the next handshake.
REQ-034 A frame_err frame SHALL still be delivered; a break (rxd held low) SHALL give one frame_err word, after which the FSM SHALL wait in IDLE for rxd to go high before arming edge detection again.

Reset
REQ-035 While rst = 0, the block SHALL hold: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, FSM in IDLE, counters 0, synchroniser FFs = 1.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no output; after release the block SHALL wait for a new start edge.

Verification
Benches use CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16, so DIV=1 and one bit is 16 clocks.
REQ-037 8N1, byte 0xA5, rx_ready = 1 -> rx_data = 0xA5 with rx_valid high for 1 cycle, no error flags set.
REQ-038 8E1, byte 0x03 sent with a wrong parity bit of 1 -> rx_data = 0x03, parity_err = 1; the same byte with parity 0 -> parity_err = 0.
REQ-039 A 5-clock low glitch on an idle line -> no rx_valid, busy returns to 0 by about clock 10, and the next valid frame 0x5A is received correctly.
REQ-040 Bytes 0x11, 0x22, 0x33 sent back-to-back with rx_ready = 0 -> 0x11 held, overrun = 1; raising rx_ready for 1 cycle -> 0x11 accepted, overrun = 0.
REQ-041 8N2 with the second stop bit low -> frame_err = 1; a 30-bit break -> exactly one word 0x00 with frame_err = 1 and no further words until rxd goes high.
REQ-042 rst pulled low at data bit 4 of 0xFF, then released and 0x81 sent -> only 0x81 is delivered, and all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_rx_framed.sv
// UART receiver: 2-FF synchroniser, oversampled majority-vote bit recovery,
// optional parity, 1 or 2 stop bits, and a one-word holding register with overrun.
module uart_rx_framed #(
  parameter int CLK_FREQ   = 65_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state;
  logic                 sync_a, sync_b;
  logic                 armed;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 smp_a, smp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_f, fr_err_f;

  logic rxd_s, tick, maj, at_maj, at_end, last_stop, handshake;

  assign rxd_s     = sync_b;
  assign tick      = (div_cnt == DIV_LAST);
  assign maj       = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
  assign at_maj    = tick && (samp_cnt == S_HI);
  assign at_end    = tick && (samp_cnt == S_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign handshake = rx_valid && rx_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sync_a     <= 1'b1;
      sync_b     <= 1'b1;
      armed      <= 1'b0;
      div_cnt    <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      shreg      <= '0;
      par_err_f  <= 1'b0;
      fr_err_f   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_a  <= rxd;
      sync_b  <= sync_a;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);

      if (handshake) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (state != ST_IDLE && tick) begin
        samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
        if (samp_cnt == S_LO)  smp_a <= rxd_s;
        if (samp_cnt == S_MID) smp_b <= rxd_s;
      end

      case (state)
        ST_IDLE: begin
          samp_cnt <= '0;
          // Edge detection re-arms only after the line has been seen high (break handling).
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= ST_START;
            armed     <= 1'b0;
            div_cnt   <= '0;
            par_err_f <= 1'b0;
            fr_err_f  <= 1'b0;
          end
        end
        ST_START: begin
          if (at_maj && maj) begin
            state <= ST_IDLE;
          end else if (at_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (at_maj) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == BIT_LAST) begin
              state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (at_maj) par_err_f <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
          if (at_end) begin
            state    <= ST_STOP;
            stop_cnt <= 1'b0;
          end
        end
        ST_STOP: begin
          if (at_maj) begin
            if (!maj) fr_err_f <= 1'b1;
            if (last_stop) begin
              // Commit at the final stop majority so a back-to-back start edge is caught.
              state <= ST_IDLE;
              armed <= maj;
              if (!rx_valid || handshake) begin
                rx_data    <= shreg;
                parity_err <= par_err_f;
                frame_err  <= fr_err_f | ~maj;
                rx_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else if (at_end) begin
            stop_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_framed;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_ready = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;

  logic [7:0] data_a, data_b, data_c;
  logic valid_a, pe_a, fe_a, ov_a, busy_a;
  logic valid_b, pe_b, fe_b, ov_b, busy_b;
  logic valid_c, pe_c, fe_c, ov_c, busy_c;

  int total = 0;
  int bad = 0;

  int hs_a = 0, hs_b = 0, hs_c = 0, vcyc_a = 0;
  logic [7:0] last_d_a = '0, last_d_b = '0, last_d_c = '0;
  logic last_pe_a = 0, last_fe_a = 0, last_pe_b = 0, last_fe_b = 0, last_pe_c = 0, last_fe_c = 0;

  always #5 clk = ~clk;

  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rx_ready), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rx_ready), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b));

  uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .rxd(rxd_c), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(rx_ready), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c), .busy(busy_c));

  // Handshake collectors: record every accepted word per instance.
  always @(posedge clk) begin
    if (valid_a) vcyc_a <= vcyc_a + 1;
    if (valid_a && rx_ready) begin
      hs_a <= hs_a + 1; last_d_a <= data_a; last_pe_a <= pe_a; last_fe_a <= fe_a;
    end
    if (valid_b && rx_ready) begin
      hs_b <= hs_b + 1; last_d_b <= data_b; last_pe_b <= pe_b; last_fe_b <= fe_b;
    end
    if (valid_c && rx_ready) begin
      hs_c <= hs_c + 1; last_d_c <= data_c; last_pe_c <= pe_c; last_fe_c <= fe_c;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int ln, input logic v);
    case (ln)
      0: rxd_a = v;
      1: rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic send_bits(input int ln, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(ln, bits[i]);
      idle(16);
    end
    set_line(ln, 1'b1);
  endtask

  task automatic test_reset();
    idle(3);
    total++;
    if ({data_a, valid_a, pe_a, fe_a, ov_a, busy_a} !== 13'h0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {data_a, valid_a, pe_a, fe_a, ov_a, busy_a});
    end
    total++;
    if ({data_b, valid_b, pe_b, fe_b, ov_b, busy_b, data_c, valid_c, pe_c, fe_c, ov_c, busy_c} !== 26'h0) begin
      bad++; $display("FAIL reset_bc: outputs not all zero during reset");
    end
    rst = 1'b1;
    idle(5);
    $display("reset: outputs checked, released");
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3];
    int h0, v0;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      h0 = hs_a; v0 = vcyc_a;
      send_bits(0, {6'b0, 1'b1, bytes[k], 1'b0}, 10);
      idle(20);
      total++;
      if (hs_a - h0 !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", hs_a - h0); end
      total++;
      if (last_d_a !== bytes[k]) begin bad++; $display("FAIL basic_data: got %h want %h", last_d_a, bytes[k]); end
      total++;
      if ({last_pe_a, last_fe_a} !== 2'b00) begin bad++; $display("FAIL basic_flags: got %b want 00", {last_pe_a, last_fe_a}); end
      total++;
      if (vcyc_a - v0 !== 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc_a - v0); end
      $display("8N1 byte %h -> %h pe=%b fe=%b", bytes[k], last_d_a, last_pe_a, last_fe_a);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d [3];
    logic p [3];
    logic exp_pe [3];
    d[0] = 8'h03; p[0] = 1'b1; exp_pe[0] = 1'b1;
    d[1] = 8'h03; p[1] = 1'b0; exp_pe[1] = 1'b0;
    d[2] = 8'h07; p[2] = 1'b1; exp_pe[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int h0;
      h0 = hs_b;
      send_bits(1, {5'b0, 1'b1, p[k], d[k], 1'b0}, 11);
      idle(20);
      total++;
      if (hs_b - h0 !== 1) begin bad++; $display("FAIL parity_count: got %0d want 1", hs_b - h0); end
      total++;
      if ({last_d_b, last_pe_b, last_fe_b} !== {d[k], exp_pe[k], 1'b0}) begin
        bad++; $display("FAIL parity_word: got %h/%b/%b want %h/%b/0", last_d_b, last_pe_b, last_fe_b, d[k], exp_pe[k]);
      end
      $display("8E1 byte %h p=%b -> %h pe=%b", d[k], p[k], last_d_b, last_pe_b);
    end
  endtask

  task automatic test_glitch();
    int h0;
    h0 = hs_a;
    set_line(0, 1'b0);
    idle(4);
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise: got %b want 1", busy_a); end
    idle(1);
    set_line(0, 1'b1);
    idle(11);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall: got %b want 0", busy_a); end
    idle(30);
    total++;
    if (hs_a - h0 !== 0) begin bad++; $display("FAIL glitch_no_word: got %0d want 0", hs_a - h0); end
    send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    idle(20);
    total++;
    if (hs_a - h0 !== 1 || last_d_a !== 8'h5A) begin
      bad++; $display("FAIL glitch_next_frame: got %0d words last %h want 1 word 5a", hs_a - h0, last_d_a);
    end
    $display("glitch: rejected, next frame %h", last_d_a);
  endtask

  task automatic test_back_to_back();
    int h0;
    h0 = hs_a;
    rx_ready = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    send_bits(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
    idle(20);
    total++;
    if ({valid_a, data_a, ov_a} !== {1'b1, 8'h11, 1'b1}) begin
      bad++; $display("FAIL b2b_held: got v=%b d=%h ov=%b want v=1 d=11 ov=1", valid_a, data_a, ov_a);
    end
    total++;
    if (hs_a - h0 !== 0) begin bad++; $display("FAIL b2b_no_accept: got %0d want 0", hs_a - h0); end
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    total++;
    if (hs_a - h0 !== 1 || last_d_a !== 8'h11) begin
      bad++; $display("FAIL b2b_accept: got %0d words last %h want 1 word 11", hs_a - h0, last_d_a);
    end
    total++;
    if ({valid_a, ov_a} !== 2'b00) begin bad++; $display("FAIL b2b_cleared: got v=%b ov=%b want 0 0", valid_a, ov_a); end
    idle(5);
    rx_ready = 1'b1;
    $display("back-to-back: accepted %h, overrun cleared", last_d_a);
  endtask

  task automatic test_stop_and_break();
    int h0;
    h0 = hs_c;
    send_bits(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    idle(20);
    total++;
    if (hs_c - h0 !== 1 || {last_d_c, last_pe_c, last_fe_c} !== {8'h55, 1'b0, 1'b1}) begin
      bad++; $display("FAIL stop2_low: got %0d words %h/%b/%b want 1 word 55/0/1", hs_c - h0, last_d_c, last_pe_c, last_fe_c);
    end
    $display("8N2 stop2 low -> %h fe=%b", last_d_c, last_fe_c);
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'h96, 1'b0}, 11);
    idle(20);
    total++;
    if (hs_c - h0 !== 2 || {last_d_c, last_fe_c} !== {8'h96, 1'b0}) begin
      bad++; $display("FAIL stop2_ok: got %0d words %h fe=%b want 2 words 96 fe=0", hs_c - h0, last_d_c, last_fe_c);
    end
    $display("8N2 good -> %h fe=%b", last_d_c, last_fe_c);
    h0 = hs_c;
    set_line(2, 1'b0);
    idle(480);
    total++;
    if (hs_c - h0 !== 1 || {last_d_c, last_fe_c} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL break_word: got %0d words %h fe=%b want 1 word 00 fe=1", hs_c - h0, last_d_c, last_fe_c);
    end
    set_line(2, 1'b1);
    idle(40);
    total++;
    if (hs_c - h0 !== 1) begin bad++; $display("FAIL break_single: got %0d want 1", hs_c - h0); end
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(20);
    total++;
    if (hs_c - h0 !== 2 || {last_d_c, last_fe_c} !== {8'h3C, 1'b0}) begin
      bad++; $display("FAIL break_rearm: got %0d words %h fe=%b want 2 words 3c fe=0", hs_c - h0, last_d_c, last_fe_c);
    end
    $display("break: one word fe=1, rearmed -> %h", last_d_c);
  endtask

  task automatic test_reset_mid_frame();
    int h0;
    rx_ready = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    idle(20);
    total++;
    if ({valid_a, data_a} !== {1'b1, 8'hC3}) begin
      bad++; $display("FAIL rstmid_held: got v=%b d=%h want v=1 d=c3", valid_a, data_a);
    end
    h0 = hs_a;
    send_bits(0, {11'b0, 4'hF, 1'b0}, 5);
    set_line(0, 1'b1);
    idle(8);
    rst = 1'b0;
    idle(2);
    total++;
    if ({data_a, valid_a, pe_a, fe_a, ov_a, busy_a} !== 13'h0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0", {data_a, valid_a, pe_a, fe_a, ov_a, busy_a});
    end
    idle(4);
    rst = 1'b1;
    rx_ready = 1'b1;
    idle(16 * 4 + 20);
    send_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
    idle(20);
    total++;
    if (hs_a - h0 !== 1 || last_d_a !== 8'h81) begin
      bad++; $display("FAIL rstmid_only_81: got %0d words last %h want 1 word 81", hs_a - h0, last_d_a);
    end
    $display("reset mid-frame: delivered %h", last_d_a);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_back_to_back();
    test_stop_and_break();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
